// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg
//   Shared types and constants for the SRAM arbiter and its grant logic.
//   - state_t    : access sequencer states (IDLE, ACCESS, RECOVER)
//   - strobes_t  : packed bundle of the active-low SRAM strobes plus the
//                  tristate enable, so the three bus patterns are named once
//   - PORT_CPU / PORT_LOADER : requester indices
//   - WAIT_MAX   : largest supported ACCESS-phase length
package sram_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RECOVER = 2'd2
    } state_t;

    localparam logic PORT_CPU    = 1'b0;
    localparam logic PORT_LOADER = 1'b1;

    localparam int WAIT_MAX = 15;

    typedef struct packed {
        logic ce;
        logic ub;
        logic lb;
        logic oe;
        logic we;
        logic toe;
    } strobes_t;

    // Bus idle: every strobe deasserted, bus not driven.
    localparam strobes_t STROBES_IDLE  = 6'b111110;
    // Read: chip and output enabled, bus released to the SRAM.
    localparam strobes_t STROBES_READ  = 6'b000010;
    // Write: chip and write enabled, FPGA drives the bus.
    localparam strobes_t STROBES_WRITE = 6'b000101;

endpackage

// File: rtl/sram_arbiter_grant.sv
// sram_arbiter_grant
//   Combinational winner selection between the two requesters.
//   Build option: SRAM_ARBITER_ROUND_ROBIN_EN
//     defined   -> on contention the port named by ptr wins (ptr is kept
//                  pointing at the port that did not win last time)
//     undefined -> fixed priority, the CPU port always wins
//   Ports:
//     valid  in  [1:0] request valids, index = port number
//     ptr    in        preferred port on contention (round-robin build)
//     any    out       at least one request is pending
//     winner out       index of the selected port (meaningful when any=1)
module sram_arbiter_grant
    import sram_arbiter_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic       any,
    output logic       winner
);

    assign any = |valid;

`ifdef SRAM_ARBITER_ROUND_ROBIN_EN
    always_comb begin
        winner = PORT_CPU;
        if (valid[PORT_CPU] && valid[PORT_LOADER]) begin
            winner = ptr;
        end else if (valid[PORT_LOADER]) begin
            winner = PORT_LOADER;
        end
    end
`else
    // The loader only runs while the CPU is halted, so starving it under
    // contention is harmless; the pointer is simply not consulted.
    logic unused_ptr;
    assign unused_ptr = ptr;

    always_comb begin
        winner = PORT_LOADER;
        if (valid[PORT_CPU]) begin
            winner = PORT_CPU;
        end
    end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Two-port arbiter and access sequencer for the external 1Mx16 SRAM.
//   Port 0 is the CPU memory path, port 1 a loader/DMA requester. One
//   request is accepted per IDLE cycle, then held for WAIT ACCESS cycles
//   and one RECOVER (bus turnaround) cycle.
//   Build option: SRAM_ARBITER_ROUND_ROBIN_EN selects round-robin instead
//   of fixed CPU priority (see sram_arbiter_grant).
//   Parameters: AW address width, DW data width, WAIT ACCESS cycles (1..15)
//   Ports:
//     Clk, Reset                    clock, synchronous active-high reset
//     reqN_valid/we/addr/wdata      request from port N
//     reqN_ready                    combinational accept strobe (IDLE only)
//     reqN_done                     one-cycle completion pulse (registered)
//     rdata                         last captured read data (registered)
//     ADDR, Data_write              SRAM address / write data (registered)
//     Data_read                     read data from the tristate buffer
//     tristate_output_enable        drive the SRAM data bus
//     CE, UB, LB, OE, WE            active-low SRAM strobes (registered)
//     busy                          sequencer not in IDLE
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int AW   = 20,
    parameter int DW   = 16,
    parameter int WAIT = 2
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          req0_valid,
    input  logic          req0_we,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    output logic          req0_ready,
    output logic          req0_done,
    input  logic          req1_valid,
    input  logic          req1_we,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          req1_ready,
    output logic          req1_done,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] ADDR,
    output logic [DW-1:0] Data_write,
    input  logic [DW-1:0] Data_read,
    output logic          tristate_output_enable,
    output logic          CE,
    output logic          UB,
    output logic          LB,
    output logic          OE,
    output logic          WE,
    output logic          busy
);

    localparam int CW = $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT - 1);

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          we_reg, we_next;
    logic [AW-1:0] addr_reg, addr_next;
    logic [DW-1:0] wdata_reg, wdata_next;
    logic          grant_reg, grant_next;
    logic          ptr_reg, ptr_next;
    logic [1:0]    done_reg, done_next;
    logic [DW-1:0] rdata_reg, rdata_next;
    strobes_t      strb_reg, strb_next;

    // Per-port views of the request bundles so the winner can index them.
    logic [1:0]    valid_vec;
    logic          req_we    [2];
    logic [AW-1:0] req_addr  [2];
    logic [DW-1:0] req_wdata [2];
    logic [1:0]    ready_vec;

    logic          win_any;
    logic          winner;

    assign valid_vec    = {req1_valid, req0_valid};
    assign req_we[0]    = req0_we;
    assign req_we[1]    = req1_we;
    assign req_addr[0]  = req0_addr;
    assign req_addr[1]  = req1_addr;
    assign req_wdata[0] = req0_wdata;
    assign req_wdata[1] = req1_wdata;

    sram_arbiter_grant u_grant (
        .valid  (valid_vec),
        .ptr    (ptr_reg),
        .any    (win_any),
        .winner (winner)
    );

    // Ready is withheld while Reset is high because the edge will not
    // accept anything; it is at most one-hot since winner is a single index.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ready
            assign ready_vec[gi] = (state_reg == IDLE) && !Reset && win_any
                                   && (winner == gi[0]);
        end
    endgenerate

    assign req0_ready = ready_vec[0];
    assign req1_ready = ready_vec[1];
    assign req0_done  = done_reg[0];
    assign req1_done  = done_reg[1];
    assign rdata      = rdata_reg;
    assign ADDR       = addr_reg;
    assign Data_write = wdata_reg;
    assign CE         = strb_reg.ce;
    assign UB         = strb_reg.ub;
    assign LB         = strb_reg.lb;
    assign OE         = strb_reg.oe;
    assign WE         = strb_reg.we;
    assign tristate_output_enable = strb_reg.toe;
    assign busy       = (state_reg != IDLE);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        we_next    = we_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        grant_next = grant_reg;
        ptr_next   = ptr_reg;
        rdata_next = rdata_reg;
        done_next  = '0;
        strb_next  = STROBES_IDLE;

        case (state_reg)
            IDLE: begin
                if (win_any) begin
                    state_next = ACCESS;
                    cnt_next   = WAIT_LOAD;
                    we_next    = req_we[winner];
                    addr_next  = req_addr[winner];
                    wdata_next = req_wdata[winner];
                    grant_next = winner;
                    ptr_next   = ~winner;
                end
            end
            ACCESS: begin
                if (cnt_reg == '0) begin
                    state_next = RECOVER;
                    if (!we_reg) begin
                        rdata_next = Data_read;
                    end
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            RECOVER: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Strobes and done are registered from the next state so they
        // change exactly on the edge that enters each phase.
        if (state_next == ACCESS) begin
            strb_next = we_next ? STROBES_WRITE : STROBES_READ;
        end
        if (state_next == RECOVER) begin
            done_next[grant_next] = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            grant_reg <= PORT_CPU;
            ptr_reg   <= PORT_CPU;
            done_reg  <= '0;
            rdata_reg <= '0;
            strb_reg  <= STROBES_IDLE;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            we_reg    <= we_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            grant_reg <= grant_next;
            ptr_reg   <= ptr_next;
            done_reg  <= done_next;
            rdata_reg <= rdata_next;
            strb_reg  <= strb_next;
        end
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter and access sequencer for the SLC-3 board's external 1Mx16 SRAM. It shares the single SRAM/tristate interface between the CPU memory path and a secondary requester such as a program loader or DMA engine. It also generates the active-low CE/UB/LB/OE/WE strobes with a fixed wait-state count. It sits between the requesters and the tristate buffer, replacing direct strobe generation by the state controller.

## Interface
Parameters:
- AW, 20, address width
- DW, 16, data width
- WAIT, 2, ACCESS-phase cycles per transfer; legal range 1..15

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- req0_valid / req1_valid  in  1  request pending; port 0 = CPU, port 1 = loader
- req0_we / req1_we  in  1  1 = write, 0 = read
- req0_addr / req1_addr  in  AW  word address
- req0_wdata / req1_wdata  in  DW  write data
- req0_ready / req1_ready  out  1  request accepted at this edge
- req0_done / req1_done  out  1  one-cycle completion pulse
- rdata  out  DW  read data; valid while a done is high for a read
- ADDR  out  AW  SRAM address
- Data_write  out  DW  data to the tristate buffer
- Data_read  in  DW  data from the tristate buffer
- tristate_output_enable  out  1  high = drive the SRAM data bus
- CE, UB, LB, OE, WE  out  1 each  SRAM strobes, active low
- busy  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE → ACCESS → RECOVER → IDLE.
- **IDLE**
  - If any reqN_valid is high, the grant logic picks one winner. Its reqN_ready goes high combinationally in this cycle.
  - At the edge, the winner's addr, wdata and we are latched, the grant is recorded, the wait counter loads WAIT-1, and the state moves to ACCESS.
- **ACCESS**
  - CE=0, UB=0, LB=0, ADDR = latched address.
  - Read: OE=0, WE=1, tristate_output_enable=0.
  - Write: OE=1, WE=0, tristate_output_enable=1, Data_write = latched wdata.
  - The counter decrements each cycle. At the edge where the counter is 0:
    - on a read, Data_read is captured into rdata;
    - the state moves to RECOVER.
- **RECOVER**
  - All strobes high; tristate_output_enable=0. This is the bus-turnaround cycle.
  - The granted port's done is high for this single cycle.
  - Next state is IDLE unconditionally.
- Requester rules:
  - Hold valid and all fields stable until ready is seen.
  - Valid may drop before ready; the request is then withdrawn with no side effects.
  - Ready is never high outside IDLE.
- rdata holds its value until the next read capture. On write completion rdata is unchanged.
- The arbiter never issues ready to both ports in the same cycle.
- Reset mid-transfer:
  - The next edge forces IDLE with all outputs at reset values.
  - No done is issued for the aborted transfer.
  - SRAM contents for an aborted write are unspecified.

## Timing
- All SRAM-side outputs and done/rdata are registered, so strobes are glitch-free. Only reqN_ready is combinational, from state and valids.
- Reset values:
  - CE, UB, LB, OE, WE = 1; tristate_output_enable = 0.
  - ADDR = 0, Data_write = 0, rdata = 0.
  - All ready = 0, all done = 0, busy = 0.
  - State IDLE; round-robin pointer = port 0.
- Cycle timing, with acceptance in cycle 0:
  - cycles 1..WAIT are ACCESS;
  - read capture happens at the end of cycle WAIT;
  - done and valid rdata appear in cycle WAIT+1.
- Throughput: one transfer per WAIT+2 cycles under continuous requests.
- A request asserted in the RECOVER cycle is accepted in the following IDLE cycle. There are no back-to-back ACCESS phases.

## Configuration
- Macro SRAM_ARBITER_ROUND_ROBIN_EN.
  - **Defined:** when both ports are valid, the port not granted last wins. The pointer updates at every accept.
  - **Undefined:** fixed priority; port 0 (CPU) always wins. Port 1 can starve, which is acceptable because the loader runs only while the CPU is halted.

## Structure
- Package sram_arbiter_pkg holds:
  - state enum (IDLE, ACCESS, RECOVER);
  - port-index constants PORT_CPU=0, PORT_LOADER=1;
  - WAIT_MAX=15.
- Sub-module sram_arbiter_grant: combinational winner selection from both valids and the pointer, wrapping the macro. The main module holds the FSM, counter and registers.

## Test plan
- **Single read:** req0 reads addr 0x00123; Data_read models 0xBEEF. Expect:
  - ready in cycle 0;
  - OE=0, CE=0 in cycles 1–2 (WAIT=2);
  - req0_done with rdata=0xBEEF in cycle 3.
- **Single write:** req1 writes 0xA5A5 to 0x0FFFF. Expect WE=0, tristate_output_enable=1 and Data_write=0xA5A5 for exactly WAIT cycles, then req1_done.
- **Contention:** both ports valid continuously.
  - Macro defined: grants alternate 0,1,0,1.
  - Macro undefined: every grant goes to port 0.
- **Withdrawal:** req1_valid pulses for one cycle while the arbiter is in ACCESS. Expect no req1_ready and no req1 transfer afterwards.
- **Reset mid-access:** Reset asserted in the 1st ACCESS cycle. Expect all strobes high at the next edge, no done, and busy=0.
- **WAIT=1 and WAIT=15 builds:** back-to-back reads. Expect done spacing of 3 and 17 cycles respectively.
